muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer sitting beside the ALU.
- Executes MULT/MULTU/DIV/DIVU over WIDTH cycles and performs MTHI/MTLO.
- Sequences results into the HI/LO register file one write per cycle: LO first, then HI.
- Provides busy/stall so the pipeline holds MFHI/MFLO until results land.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_enable  in  1  global advance; when 0, all state, counters and outputs hold
op_valid  in  1  operation request
op_ready  out  1  request accepted this cycle when op_valid & op_ready & clk_enable
op_code  in  3  operation encoding (package constants)
rs_data  in  WIDTH  operand A (dividend / multiplicand / MT source)
rt_data  in  WIDTH  operand B (divisor / multiplier)
mf_req  in  1  decode holds an MFHI/MFLO
stall  out  1  mf_req & busy
busy  out  1  state != IDLE
lo_wdata  out  WIDTH  LO write data
hi_wdata  out  WIDTH  HI write data
lo_we  out  1  LO write enable
hi_we  out  1  HI write enable

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. Reset takes priority over clk_enable.
- Reset values: state=IDLE, counter=0, lo_we=hi_we=0, lo_wdata=hi_wdata=0, busy=0, op_ready=1.
- States: IDLE, CALC, WR_LO, WR_HI.
- op_ready = (state==IDLE); lo_we = (state==WR_LO); hi_we = (state==WR_HI). Data outputs come from registered result regs.
- Accept edge E0:
  - MULT*/DIV* -> CALC, counter=WIDTH-1.
  - MTLO -> WR_LO with lo result=rs_data, hi_only flag clear, lo_only flag set.
  - MTHI -> WR_HI with hi result=rs_data.
  - Codes 6/7 accepted, no state change, no write.
- CALC: one radix-2 step per enabled cycle. Multiply is shift-add on a 2*WIDTH product; divide is restoring, one quotient bit per cycle. At counter==0 -> WR_LO.
- WR_LO: one cycle -> WR_HI, or -> IDLE if lo_only. WR_HI: one cycle -> IDLE.
- Latency: CALC occupies cycles 1..WIDTH after E0, lo_we at WIDTH+1, hi_we at WIDTH+2, op_ready high at WIDTH+3. MTLO/MTHI: write enable in cycle 1, ready in cycle 2.
- lo_we and hi_we are never high in the same cycle.
- Signed ops: iterate on magnitudes. Negate quotient if operand signs differ. Remainder takes the dividend's sign. Product is negated if signs differ.
- 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): LO=all-ones, HI=rs_data unmodified, full latency preserved.
- Results: LO = product[WIDTH-1:0] or quotient; HI = product[2W-1:W] or remainder.
- Reset mid-operation: abort, IDLE next cycle, no write enable asserted, HI/LO untouched.
- clk_enable low mid-CALC: counter and partial results frozen; a we held high stays high but produces one write only once enable returns.
- op_valid while busy: ignored, not queued; the requester holds op_valid.

Decomposition:
- Package muldiv_pkg: op_code localparams OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5; state enum typedef.
- Sub-module muldiv_datapath: shift-add/restoring step regs, sign fixup, div-by-zero override. muldiv_seq keeps the FSM, counter, handshake and write sequencing.

Test Plan:
1. MULT rs=0xFFFFFFFD (-3), rt=5 -> lo_we cycle 33 with LO=0xFFFFFFF1; hi_we cycle 34 with HI=0xFFFFFFFF; op_ready cycle 35.
2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> LO=0x00000001, HI=0xFFFFFFFE; never lo_we&hi_we together.
3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTLO 0x12345678 while idle -> lo_we cycle 1 with data 0x12345678, no hi_we. MTHI issued during CALC -> op_ready=0, no write. mf_req=1 during CALC -> stall=1; after WR_HI -> stall=0.
5. Reset asserted at cycle 10 of a DIVU -> IDLE next cycle, busy=0, no lo_we/hi_we; a following MULTU 3*4 -> LO=12, HI=0.
6. clk_enable low for 5 cycles mid-CALC -> completion delayed by exactly 5 cycles, results unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings and sequencer state type for the multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WR_LO,
        ST_WR_HI
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider on operand magnitudes,
// with sign fixup and divide-by-zero override into the HI/LO result regs.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             finish,
    input  logic             load_lo,
    input  logic             load_hi,
    input  logic [OP_W-1:0]  op_code,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] lo_res,
    output logic [WIDTH-1:0] hi_res
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opb;
    logic             div_mode;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic             is_div;
    logic             is_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   q_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand decode and magnitude extraction at accept time
    always_comb begin
        is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
        is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
        mag_a     = (is_signed && rs_data[WIDTH-1]) ? WIDTH'(-rs_data) : rs_data;
        mag_b     = (is_signed && rt_data[WIDTH-1]) ? WIDTH'(-rt_data) : rt_data;
    end

    // One iteration: {acc,q} is the running product or {remainder,dividend/quotient}
    always_comb begin
        addend    = q[0] ? opb : '0;
        mul_sum   = {1'b0, acc} + {1'b0, addend};
        rem_shift = {acc, q[WIDTH-1]};
        diff      = rem_shift - {1'b0, opb};
        if (!div_mode) begin
            acc_n = mul_sum[WIDTH:1];
            q_n   = {mul_sum[0], q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_n = diff[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = rem_shift[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], 1'b0};
        end
        prod     = {acc_n, q_n};
        prod_fix = neg_q ? (2*WIDTH)'(-prod) : prod;
        quo_fix  = div0 ? '1 : (neg_q ? WIDTH'(-q_n) : q_n);
        rem_fix  = neg_r ? WIDTH'(-acc_n) : acc_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            q        <= '0;
            opb      <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            lo_res   <= '0;
            hi_res   <= '0;
        end else begin
            if (start) begin
                acc      <= '0;
                q        <= mag_a;
                opb      <= mag_b;
                div_mode <= is_div;
                neg_q    <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                neg_r    <= is_signed && rs_data[WIDTH-1];
                div0     <= is_div && (rt_data == '0);
            end else if (step) begin
                acc <= acc_n;
                q   <= q_n;
            end
            if (finish) begin
                lo_res <= div_mode ? quo_fix : prod_fix[WIDTH-1:0];
                hi_res <= div_mode ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            end
            if (load_lo) begin
                lo_res <= rs_data;
            end
            if (load_hi) begin
                hi_res <= rs_data;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer: accepts one op when idle, iterates WIDTH cycles,
// then writes LO and HI on consecutive cycles; stalls MFHI/MFLO while busy.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OP_W-1:0]  op_code,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mf_req,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] lo_wdata,
    output logic [WIDTH-1:0] hi_wdata,
    output logic             lo_we,
    output logic             hi_we
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lo_only;
    logic             lo_only_next;

    logic start;
    logic step;
    logic finish;
    logic load_lo;
    logic load_hi;

    // Next state; every strobe already includes clk_enable so nothing moves while it is low
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        lo_only_next = lo_only;
        start        = 1'b0;
        step         = 1'b0;
        finish       = 1'b0;
        load_lo      = 1'b0;
        load_hi      = 1'b0;
        if (clk_enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_next   = ST_CALC;
                                cnt_next     = CNT_W'(WIDTH - 1);
                                lo_only_next = 1'b0;
                                start        = 1'b1;
                            end
                            OP_MTLO: begin
                                state_next   = ST_WR_LO;
                                lo_only_next = 1'b1;
                                load_lo      = 1'b1;
                            end
                            OP_MTHI: begin
                                state_next = ST_WR_HI;
                                load_hi    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        finish     = 1'b1;
                        state_next = ST_WR_LO;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                ST_WR_LO: state_next = lo_only ? ST_IDLE : ST_WR_HI;
                ST_WR_HI: state_next = ST_IDLE;
            endcase
        end
    end

    // Handshake and write enables registered off the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lo_only  <= 1'b0;
            op_ready <= 1'b1;
            busy     <= 1'b0;
            lo_we    <= 1'b0;
            hi_we    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            lo_only  <= lo_only_next;
            op_ready <= (state_next == ST_IDLE);
            busy     <= (state_next != ST_IDLE);
            lo_we    <= (state_next == ST_WR_LO);
            hi_we    <= (state_next == ST_WR_HI);
        end
    end

    assign stall = mf_req & busy;

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .step    (step),
        .finish  (finish),
        .load_lo (load_lo),
        .load_hi (load_hi),
        .op_code (op_code),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .lo_res  (lo_wdata),
        .hi_res  (hi_wdata)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_enable;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op_code;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         mf_req;
    logic         stall;
    logic         busy;
    logic [W-1:0] lo_wdata;
    logic [W-1:0] hi_wdata;
    logic         lo_we;
    logic         hi_we;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .mf_req     (mf_req),
        .stall      (stall),
        .busy       (busy),
        .lo_wdata   (lo_wdata),
        .hi_wdata   (hi_wdata),
        .lo_we      (lo_we),
        .hi_we      (hi_we)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        lo = '0;
        hi = '0;
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                lo = sp[31:0];
                hi = sp[63:32];
            end
            OP_MULTU: begin
                up = ua * ub;
                lo = up[31:0];
                hi = up[63:32];
            end
            OP_DIV: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            OP_DIVU: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    up = ua / ub;
                    lo = up[31:0];
                    up = ua % ub;
                    hi = up[31:0];
                end
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one op at a negedge while idle and follow it to completion
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold_at, input int hold_len,
                          input int intrude_at);
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        logic [W-1:0] lo_got;
        logic [W-1:0] hi_got;
        int exp_lo_cyc;
        int exp_hi_cyc;
        int exp_rdy;
        int lo_cnt;
        int hi_cnt;
        int lo_cyc;
        int hi_cyc;
        int rdy_cyc;
        bit is_calc;
        model(op, a, b, exp_lo, exp_hi);
        is_calc    = (op <= OP_DIVU);
        exp_lo_cyc = is_calc ? int'(W) + 1 + hold_len : (op == OP_MTLO ? 1 : -1);
        exp_hi_cyc = is_calc ? int'(W) + 2 + hold_len : (op == OP_MTHI ? 1 : -1);
        exp_rdy    = is_calc ? int'(W) + 3 + hold_len : ((op == OP_MTLO || op == OP_MTHI) ? 2 : 1);
        lo_cnt = 0; hi_cnt = 0; lo_cyc = -1; hi_cyc = -1; rdy_cyc = -1;
        lo_got = '0; hi_got = '0;

        check($sformatf("%s_ready_idle", tag), 64'(op_ready), 64'd1);
        op_valid = 1'b1;
        op_code  = op;
        rs_data  = a;
        rt_data  = b;
        @(negedge clk);
        for (int cyc = 1; cyc <= 200 && rdy_cyc < 0; cyc++) begin
            op_valid = 1'b0;
            rs_data  = $urandom;
            rt_data  = $urandom;
            mf_req   = 1'($urandom);
            if (cyc == intrude_at) begin
                check($sformatf("%s_ready_busy", tag), 64'(op_ready), 64'd0);
                op_valid = 1'b1;
                op_code  = OP_MTHI;
            end
            if (hold_at > 0 && cyc == hold_at) clk_enable = 1'b0;
            if (hold_at > 0 && cyc == hold_at + hold_len) clk_enable = 1'b1;
            #1;
            check($sformatf("%s_busy_c%0d", tag, cyc), 64'(busy), 64'(cyc < exp_rdy));
            check($sformatf("%s_stall_c%0d", tag, cyc), 64'(stall), 64'(mf_req && (cyc < exp_rdy)));
            check($sformatf("%s_both_we_c%0d", tag, cyc), 64'(lo_we & hi_we), 64'd0);
            if (lo_we && clk_enable) begin
                lo_cnt++;
                if (lo_cyc < 0) lo_cyc = cyc;
                lo_got = lo_wdata;
            end
            if (hi_we && clk_enable) begin
                hi_cnt++;
                if (hi_cyc < 0) hi_cyc = cyc;
                hi_got = hi_wdata;
            end
            if (op_ready) rdy_cyc = cyc;
            @(negedge clk);
        end
        op_valid = 1'b0;
        check($sformatf("%s_ready_cyc", tag), 64'(rdy_cyc), 64'(exp_rdy));
        check($sformatf("%s_lo_writes", tag), 64'(lo_cnt), 64'(exp_lo_cyc > 0));
        check($sformatf("%s_hi_writes", tag), 64'(hi_cnt), 64'(exp_hi_cyc > 0));
        if (exp_lo_cyc > 0) begin
            check($sformatf("%s_lo_cyc", tag), 64'(lo_cyc), 64'(exp_lo_cyc));
            check($sformatf("%s_lo_data", tag), 64'(lo_got), 64'(exp_lo));
        end
        if (exp_hi_cyc > 0) begin
            check($sformatf("%s_hi_cyc", tag), 64'(hi_cyc), 64'(exp_hi_cyc));
            check($sformatf("%s_hi_data", tag), 64'(hi_got), 64'(exp_hi));
        end
    endtask

    // Reset asserted during cycle 10 of a DIVU must abort without any write
    task automatic reset_abort();
        int writes;
        writes   = 0;
        op_valid = 1'b1;
        op_code  = OP_DIVU;
        rs_data  = $urandom;
        rt_data  = $urandom;
        @(negedge clk);
        op_valid = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_busy", 64'(busy), 64'd0);
        check("rst_abort_ready", 64'(op_ready), 64'd1);
        check("rst_abort_lo_we", 64'(lo_we), 64'd0);
        check("rst_abort_hi_we", 64'(hi_we), 64'd0);
        reset = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (lo_we || hi_we) writes++;
            @(negedge clk);
        end
        check("rst_abort_no_writes", 64'(writes), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        reset      = 1'b1;
        clk_enable = 1'b1;
        op_valid   = 1'b0;
        op_code    = '0;
        rs_data    = '0;
        rt_data    = '0;
        mf_req     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_we", 64'({lo_we, hi_we}), 64'd0);
        check("rst_lo_wdata", 64'(lo_wdata), 64'd0);
        check("rst_hi_wdata", 64'(hi_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, 0, -1);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 0, -1);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, -1, 0, -1);
        run_op("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, -1, 0, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, -1);
        run_op("mtlo", OP_MTLO, 32'h1234_5678, 32'd0, -1, 0, -1);
        run_op("mthi", OP_MTHI, 32'hCAFE_F00D, 32'd0, -1, 0, -1);
        run_op("mult_intrude", OP_MULT, 32'h0001_2345, 32'hFFFF_8000, -1, 0, 15);
        run_op("code6", 3'd6, 32'hDEAD_BEEF, 32'd1, -1, 0, -1);
        run_op("code7", 3'd7, 32'hDEAD_BEEF, 32'd1, -1, 0, -1);
        run_op("divu_hold", OP_DIVU, 32'hF000_1234, 32'd13, 10, 5, -1);
        run_op("mult_hold", OP_MULT, 32'h8000_0000, 32'h8000_0000, 20, 5, -1);

        reset_abort();
        run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, -1, 0, -1);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d", i), rop, pick(), pick(),
                   ($urandom_range(0, 3) == 0 && rop <= OP_DIVU) ? int'($urandom_range(2, 25)) : -1,
                   0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
